// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU front-end: opcode and FSM state
// encodings, data width, and the illegal-opcode boundary.
package alu_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_NEG    = 4'b0010,
        OP_INC    = 4'b0011,
        OP_DEC    = 4'b0100,
        OP_ROTL   = 4'b0101,
        OP_OR     = 4'b0110,
        OP_AND    = 4'b0111,
        OP_XOR    = 4'b1000,
        OP_MAX    = 4'b1001,
        OP_PASS_A = 4'b1010,
        OP_PASS_B = 4'b1011
    } alu_op_e;

    localparam logic [3:0] OP_ILLEGAL_MIN = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic op_is_illegal(input logic [3:0] op);
        return (op >= OP_ILLEGAL_MIN);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_alu.sv
// 4-bit combinational ALU. Carry is the raw adder carry-out (subtraction
// carries when no borrow); overflow is signed two's-complement overflow.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [3:0]        ALUcontrol,
    output logic [DATA_W-1:0] Result,
    output logic              CarryOut,
    output logic              Overflow
);

    logic [DATA_W:0] w_sum;

    // Opcode decode; adder-based ops share a 5-bit sum for the carry bit
    always_comb begin
        w_sum    = '0;
        Result   = '0;
        CarryOut = 1'b0;
        Overflow = 1'b0;
        case (ALUcontrol)
            OP_ADD: begin
                w_sum    = {1'b0, A} + {1'b0, B};
                Result   = w_sum[DATA_W-1:0];
                CarryOut = w_sum[DATA_W];
                Overflow = (A[3] == B[3]) && (w_sum[3] != A[3]);
            end
            OP_SUB: begin
                w_sum    = {1'b0, A} + {1'b0, ~B} + 5'd1;
                Result   = w_sum[DATA_W-1:0];
                CarryOut = w_sum[DATA_W];
                Overflow = (A[3] != B[3]) && (w_sum[3] != A[3]);
            end
            OP_NEG: begin
                w_sum    = {1'b0, ~A} + 5'd1;
                Result   = w_sum[DATA_W-1:0];
                CarryOut = w_sum[DATA_W];
                Overflow = A[3] && w_sum[3];
            end
            OP_INC: begin
                w_sum    = {1'b0, A} + 5'd1;
                Result   = w_sum[DATA_W-1:0];
                CarryOut = w_sum[DATA_W];
                Overflow = !A[3] && w_sum[3];
            end
            OP_DEC: begin
                w_sum    = {1'b0, A} + 5'b01111;
                Result   = w_sum[DATA_W-1:0];
                CarryOut = w_sum[DATA_W];
                Overflow = A[3] && !w_sum[3];
            end
            OP_ROTL:   Result = {A[2:0], A[3]};
            OP_OR:     Result = A | B;
            OP_AND:    Result = A & B;
            OP_XOR:    Result = A ^ B;
            OP_MAX:    Result = ($signed(A) > $signed(B)) ? A : B;
            OP_PASS_A: Result = A;
            OP_PASS_B: Result = B;
            default:   Result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Clocked command/response front-end around the 4-bit ALU.
// Optional accumulator chaining is enabled by defining ALU_ACC_CHAIN_EN.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_use_acc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_carry,
    output logic              rsp_overflow,
    output logic              rsp_illegal,
    output logic [CNT_W-1:0]  op_count
);

    state_e             r_state;
    logic [3:0]         r_op;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic               r_cmd_ready;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_result;
    logic               r_carry;
    logic               r_overflow;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_count;

    logic [DATA_W-1:0]  w_alu_result;
    logic               w_alu_carry;
    logic               w_alu_overflow;
    logic               w_illegal;

`ifdef ALU_ACC_CHAIN_EN
    logic [DATA_W-1:0]  r_acc;
    logic [DATA_W-1:0]  w_a_sel;
    assign w_a_sel = cmd_use_acc ? r_acc : cmd_a;
`else
    logic [DATA_W-1:0]  w_a_sel;
    logic               w_unused_use_acc;
    assign w_a_sel          = cmd_a;
    assign w_unused_use_acc = cmd_use_acc;
`endif

    assign w_illegal = op_is_illegal(r_op);

    alu u_alu (
        .A          (r_a),
        .B          (r_b),
        .ALUcontrol (r_op),
        .Result     (w_alu_result),
        .CarryOut   (w_alu_carry),
        .Overflow   (w_alu_overflow)
    );

    // Control FSM: accept, execute for one cycle, then hold the response until consumed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= 4'd0;
            r_a         <= '0;
            r_b         <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_illegal   <= 1'b0;
            r_count     <= '0;
`ifdef ALU_ACC_CHAIN_EN
            r_acc       <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_op        <= cmd_op;
                        r_a         <= w_a_sel;
                        r_b         <= cmd_b;
                        r_cmd_ready <= 1'b0;
                        r_state     <= EXEC;
                    end else begin
                        r_state     <= IDLE;
                    end
                end
                EXEC: begin
                    // Illegal opcodes report all-zero data regardless of ALU output
                    r_result    <= w_illegal ? '0   : w_alu_result;
                    r_carry     <= w_illegal ? 1'b0 : w_alu_carry;
                    r_overflow  <= w_illegal ? 1'b0 : w_alu_overflow;
                    r_illegal   <= w_illegal;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
`ifdef ALU_ACC_CHAIN_EN
                    if (!w_illegal) begin
                        r_acc <= w_alu_result;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_count     <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_state     <= RESP;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_result;
    assign rsp_carry    = r_carry;
    assign rsp_overflow = r_overflow;
    assign rsp_illegal  = r_illegal;
    assign op_count     = r_count;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed vector table, chaining and
// reset sequences, then randomized ops against an arithmetic reference model.
module tb_alu_seq_ctrl;

    localparam int TB_CNT_W = 3;

    logic                clk;
    logic                rst_n;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [3:0]          cmd_op;
    logic [3:0]          cmd_a;
    logic [3:0]          cmd_b;
    logic                cmd_use_acc;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [3:0]          rsp_result;
    logic                rsp_carry;
    logic                rsp_overflow;
    logic                rsp_illegal;
    logic [TB_CNT_W-1:0] op_count;

    int n_checks = 0;
    int n_errors = 0;
    int m_count  = 0;
    logic [3:0] m_acc = 4'd0;

    alu_seq_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_use_acc  (cmd_use_acc),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_carry    (rsp_carry),
        .rsp_overflow (rsp_overflow),
        .rsp_illegal  (rsp_illegal),
        .op_count     (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        int         hold;
        logic [3:0] res;
        logic       c;
        logic       v;
        logic       il;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model from the opcode definitions, using plain integer arithmetic
    function automatic void ref_alu(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                                    output logic [3:0] r, output logic c, output logic v,
                                    output logic il);
        int ua, ub, sa, sb, t;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        t  = 0;
        r  = 4'd0; c = 1'b0; v = 1'b0; il = 1'b0;
        case (op)
            4'd0:  begin t = ua + ub;            c = (t > 15);   v = (sa + sb > 7) || (sa + sb < -8); end
            4'd1:  begin t = (ua - ub + 16) % 16; c = (ua >= ub); v = (sa - sb > 7) || (sa - sb < -8); end
            4'd2:  begin t = (16 - ua) % 16;     c = (ua == 0);  v = (sa == -8); end
            4'd3:  begin t = ua + 1;             c = (ua == 15); v = (sa == 7); end
            4'd4:  begin t = ua + 15;            c = (ua != 0);  v = (sa == -8); end
            4'd5:  t = (ua * 2) % 16 + ua / 8;
            4'd6:  t = int'(a | b);
            4'd7:  t = int'(a & b);
            4'd8:  t = int'(a ^ b);
            4'd9:  t = (sa > sb) ? ua : ub;
            4'd10: t = ua;
            4'd11: t = ub;
            default: il = 1'b1;
        endcase
        r = t[3:0];
    endfunction

    // One full transaction starting at a negedge with the DUT idle
    task automatic do_op(input string name, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic use_acc, input int hold,
                         input logic [3:0] er, input logic ec, input logic ev, input logic ei);
        check({name, ".idle_ready"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = use_acc;
        rsp_ready   = (hold == 0);
        @(negedge clk);
        cmd_valid   = 1'($urandom_range(0, 1));
        cmd_op      = 4'($urandom);
        cmd_a       = 4'($urandom);
        cmd_b       = 4'($urandom);
        cmd_use_acc = 1'($urandom_range(0, 1));
        check({name, ".exec_ready"}, {31'd0, cmd_ready}, 32'd0);
        check({name, ".exec_valid"}, {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check({name, ".latency"},  {31'd0, rsp_valid},    32'd1);
        check({name, ".result"},   {28'd0, rsp_result},   {28'd0, er});
        check({name, ".carry"},    {31'd0, rsp_carry},    {31'd0, ec});
        check({name, ".overflow"}, {31'd0, rsp_overflow}, {31'd0, ev});
        check({name, ".illegal"},  {31'd0, rsp_illegal},  {31'd0, ei});
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({name, ".bp_valid"},  {31'd0, rsp_valid},  32'd1);
            check({name, ".bp_ready"},  {31'd0, cmd_ready},  32'd0);
            check({name, ".bp_result"}, {28'd0, rsp_result}, {28'd0, er});
            check({name, ".bp_flags"},  {29'd0, rsp_carry, rsp_overflow, rsp_illegal}, {29'd0, ec, ev, ei});
            check({name, ".bp_count"},  {29'd0, op_count},   32'(m_count % 8));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        m_count++;
`ifdef ALU_ACC_CHAIN_EN
        if (!ei) m_acc = er;
`endif
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        check({name, ".done_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({name, ".done_ready"}, {31'd0, cmd_ready}, 32'd1);
        check({name, ".count"},      {29'd0, op_count},  32'(m_count % 8));
    endtask

    // Model-driven op: resolves accumulator substitution, then runs the transaction
    task automatic model_op(input string name, input logic [3:0] op, input logic [3:0] a,
                            input logic [3:0] b, input logic use_acc, input int hold);
        logic [3:0] a_eff, r;
        logic c, v, il;
`ifdef ALU_ACC_CHAIN_EN
        a_eff = use_acc ? m_acc : a;
`else
        a_eff = a;
`endif
        ref_alu(op, a_eff, b, r, c, v, il);
        do_op(name, op, a, b, use_acc, hold, r, c, v, il);
    endtask

    initial begin
        vecs[0]  = '{4'b0000, 4'd3,    4'd4,    0, 4'd7,    1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'b0000, 4'd5,    4'd4,    0, 4'b1001, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{4'b1001, 4'b1110, 4'd1,    4, 4'd1,    1'b0, 1'b0, 1'b0};
        vecs[3]  = '{4'b1100, 4'd3,    4'd6,    1, 4'd0,    1'b0, 1'b0, 1'b1};
        vecs[4]  = '{4'b0001, 4'd3,    4'd5,    0, 4'b1110, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'b0001, 4'd5,    4'd3,    0, 4'd2,    1'b1, 1'b0, 1'b0};
        vecs[6]  = '{4'b0010, 4'b1000, 4'd0,    0, 4'b1000, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{4'b0011, 4'b0111, 4'd0,    2, 4'b1000, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{4'b0100, 4'b0000, 4'd0,    0, 4'b1111, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'b0101, 4'b1001, 4'd0,    0, 4'b0011, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'b1000, 4'b1100, 4'b1010, 0, 4'b0110, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{4'b1011, 4'd0,    4'b1101, 0, 4'b1101, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{4'b0000, 4'b1111, 4'd1,    0, 4'd0,    1'b1, 1'b0, 1'b0};
        vecs[13] = '{4'b1111, 4'd7,    4'd7,    0, 4'd0,    1'b0, 1'b0, 1'b1};
        vecs[14] = '{4'b0010, 4'd0,    4'd0,    0, 4'd0,    1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 4'd0; cmd_b = 4'd0;
        cmd_use_acc = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst.result",    {28'd0, rsp_result}, 32'd0);
        check("rst.flags",     {29'd0, rsp_carry, rsp_overflow, rsp_illegal}, 32'd0);
        check("rst.count",     {29'd0, op_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].hold,
                  vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].il);
        end

        // Accumulator chain; the illegal op in the middle must leave the accumulator alone
        do_op("chain0", 4'b1010, 4'd3, 4'd0, 1'b0, 0, 4'd3, 1'b0, 1'b0, 1'b0);
`ifdef ALU_ACC_CHAIN_EN
        do_op("chain1", 4'b0011, 4'd0, 4'd0, 1'b1, 0, 4'd4, 1'b0, 1'b0, 1'b0);
        do_op("chain2", 4'b1101, 4'd9, 4'd2, 1'b1, 0, 4'd0, 1'b0, 1'b0, 1'b1);
        do_op("chain3", 4'b0101, 4'd0, 4'd0, 1'b1, 0, 4'b1000, 1'b0, 1'b0, 1'b0);
`else
        do_op("chain1", 4'b0011, 4'd0, 4'd0, 1'b1, 0, 4'd1, 1'b0, 1'b0, 1'b0);
        do_op("chain2", 4'b1101, 4'd9, 4'd2, 1'b1, 0, 4'd0, 1'b0, 1'b0, 1'b1);
        do_op("chain3", 4'b0101, 4'd0, 4'd0, 1'b1, 0, 4'd0, 1'b0, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            model_op("rand", 4'($urandom), 4'($urandom), 4'($urandom),
                     1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        // Reset asserted during EXEC discards the in-flight command
        cmd_valid = 1'b1; cmd_op = 4'b0000; cmd_a = 4'd1; cmd_b = 4'd1; cmd_use_acc = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("mid.in_exec", {31'd0, cmd_ready}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_count = 0;
        m_acc   = 4'd0;
        check("mid.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("mid.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid.result",    {28'd0, rsp_result}, 32'd0);
        check("mid.count",     {29'd0, op_count}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid.no_rsp",  {31'd0, rsp_valid}, 32'd0);
            check("mid.count_z", {29'd0, op_count}, 32'd0);
        end
        rsp_ready = 1'b0;

        model_op("post_rst", 4'b0000, 4'd2, 4'd3, 1'b1, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
